// File: rtl/ddr3_rw_arbiter_if.sv
// Bundle of write-FIFO, read-FIFO and MIG app signals between the arbiter (master)
// and the FIFO/MIG side (slave).
`timescale 1ns/1ps
interface ddr3_rw_arbiter_if #(
    parameter int APP_DW = 256,
    parameter int ADDR_W = 28,
    parameter int CNT_W  = 9
);
    logic [CNT_W-1:0]  wrfifo_rd_cnt;
    logic [APP_DW-1:0] wrfifo_dout;
    logic              wrfifo_rden;
    logic [CNT_W-1:0]  rdfifo_wr_cnt;
    logic              rdfifo_wren;
    logic [APP_DW-1:0] rdfifo_din;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [APP_DW-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [APP_DW-1:0] app_rd_data;
    logic              app_rd_data_valid;

    modport master (
        input  wrfifo_rd_cnt, wrfifo_dout, rdfifo_wr_cnt,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output wrfifo_rden, rdfifo_wren, rdfifo_din,
               app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output wrfifo_rd_cnt, wrfifo_dout, rdfifo_wr_cnt,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  wrfifo_rden, rdfifo_wren, rdfifo_din,
               app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/ddr3_rw_arbiter.sv
// Round-robin scheduler of fixed-length write and read bursts onto the single MIG
// app command port, each direction walking its own circular address window.
`timescale 1ns/1ps
module ddr3_rw_arbiter #(
    parameter int APP_DW        = 256,
    parameter int ADDR_W        = 28,
    parameter int BURST_LEN     = 8,
    parameter int ADDR_STEP     = 8,
    parameter int WR_ADDR_BEGIN = 0,
    parameter int WR_ADDR_END   = 511,
    parameter int RD_ADDR_BEGIN = 0,
    parameter int RD_ADDR_END   = 511,
    parameter int FIFO_DEPTH    = 64,
    parameter int CNT_W         = 9
) (
    input  logic               ui_clk,
    input  logic               ui_rst_n,
    input  logic               init_calib_complete,
    input  logic               wr_addr_clr,
    input  logic               rd_addr_clr,
    ddr3_rw_arbiter_if.master  bus
);
    localparam int BCNT_W = $clog2(BURST_LEN);
    localparam int VCNT_W = BCNT_W + 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic              last_rd_q, last_rd_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [BCNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [VCNT_W-1:0] vld_cnt_q, vld_cnt_d;
    logic              wr_clr_pend_q, wr_clr_pend_d;
    logic              rd_clr_pend_q, rd_clr_pend_d;
    logic              rdfifo_wren_q;
    logic [APP_DW-1:0] rdfifo_din_q;

    logic wr_req, rd_req, wr_beat;
    logic app_en_c, wrfifo_rden_c;

    // One bit of headroom in the sum keeps the END comparison from wrapping.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input int first_a, input int last_a);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + (ADDR_W+1)'(ADDR_STEP);
        if (sum > (ADDR_W+1)'(last_a))
            return ADDR_W'(first_a);
        return sum[ADDR_W-1:0];
    endfunction

    assign wr_req  = init_calib_complete && (bus.wrfifo_rd_cnt >= CNT_W'(BURST_LEN));
    assign rd_req  = init_calib_complete &&
                     (({1'b0, bus.rdfifo_wr_cnt} + (CNT_W+1)'(BURST_LEN)) <= (CNT_W+1)'(FIFO_DEPTH));
    assign wr_beat = bus.app_rdy && bus.app_wdf_rdy;

    always_comb begin
        state_d       = state_q;
        last_rd_d     = last_rd_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        cmd_cnt_d     = cmd_cnt_q;
        vld_cnt_d     = vld_cnt_q;
        wr_clr_pend_d = wr_clr_pend_q | wr_addr_clr;
        rd_clr_pend_d = rd_clr_pend_q | rd_addr_clr;
        app_en_c      = 1'b0;
        wrfifo_rden_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_clr_pend_q || rd_clr_pend_q) begin
                    if (wr_clr_pend_q) wr_addr_d = ADDR_W'(WR_ADDR_BEGIN);
                    if (rd_clr_pend_q) rd_addr_d = ADDR_W'(RD_ADDR_BEGIN);
                    wr_clr_pend_d = wr_addr_clr;
                    rd_clr_pend_d = rd_addr_clr;
                end else if (wr_req && (!rd_req || last_rd_q)) begin
                    state_d   = WR_BURST;
                    last_rd_d = 1'b0;
                    cmd_cnt_d = '0;
                end else if (rd_req) begin
                    state_d   = RD_CMD;
                    last_rd_d = 1'b1;
                    cmd_cnt_d = '0;
                    vld_cnt_d = '0;
                end
            end
            WR_BURST: begin
                app_en_c      = bus.app_wdf_rdy;
                wrfifo_rden_c = wr_beat;
                if (wr_beat) begin
                    wr_addr_d = step_addr(wr_addr_q, WR_ADDR_BEGIN, WR_ADDR_END);
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    if (cmd_cnt_q == BCNT_W'(BURST_LEN - 1)) state_d = IDLE;
                end
            end
            RD_CMD: begin
                app_en_c  = 1'b1;
                vld_cnt_d = vld_cnt_q + VCNT_W'(bus.app_rd_data_valid);
                if (bus.app_rdy) begin
                    rd_addr_d = step_addr(rd_addr_q, RD_ADDR_BEGIN, RD_ADDR_END);
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    if (cmd_cnt_q == BCNT_W'(BURST_LEN - 1)) state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                vld_cnt_d = vld_cnt_q + VCNT_W'(bus.app_rd_data_valid);
                if (vld_cnt_d >= VCNT_W'(BURST_LEN)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q       <= IDLE;
            last_rd_q     <= 1'b1;
            wr_addr_q     <= ADDR_W'(WR_ADDR_BEGIN);
            rd_addr_q     <= ADDR_W'(RD_ADDR_BEGIN);
            cmd_cnt_q     <= '0;
            vld_cnt_q     <= '0;
            wr_clr_pend_q <= 1'b0;
            rd_clr_pend_q <= 1'b0;
            rdfifo_wren_q <= 1'b0;
            rdfifo_din_q  <= '0;
        end else begin
            state_q       <= state_d;
            last_rd_q     <= last_rd_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            cmd_cnt_q     <= cmd_cnt_d;
            vld_cnt_q     <= vld_cnt_d;
            wr_clr_pend_q <= wr_clr_pend_d;
            rd_clr_pend_q <= rd_clr_pend_d;
            rdfifo_wren_q <= bus.app_rd_data_valid;
            rdfifo_din_q  <= bus.app_rd_data;
        end
    end

    // Only the handshake strobes are combinational; address and command come from flops.
    assign bus.app_en       = app_en_c;
    assign bus.wrfifo_rden  = wrfifo_rden_c;
    assign bus.app_wdf_wren = wrfifo_rden_c;
    assign bus.app_wdf_end  = wrfifo_rden_c;
    assign bus.app_wdf_data = bus.wrfifo_dout;
    assign bus.app_addr     = (state_q == RD_CMD) ? rd_addr_q : wr_addr_q;
    assign bus.app_cmd      = (state_q == RD_CMD) ? 3'b001 : 3'b000;
    assign bus.rdfifo_wren  = rdfifo_wren_q;
    assign bus.rdfifo_din   = rdfifo_din_q;
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench: expected app commands, write data and read-FIFO pushes are queued
// as stimulus is set up and popped as the arbiter produces them.
`timescale 1ns/1ps
module tb_ddr3_rw_arbiter;
    localparam int APP_DW = 256;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 9;
    localparam int BL     = 8;
    localparam int FDEPTH = 64;

    logic ui_clk = 1'b0;
    logic ui_rst_n = 1'b0;
    logic init_calib_complete = 1'b0;
    logic wr_addr_clr = 1'b0;
    logic rd_addr_clr = 1'b0;

    ddr3_rw_arbiter_if #(.APP_DW(APP_DW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    ddr3_rw_arbiter #(
        .APP_DW(APP_DW), .ADDR_W(ADDR_W), .BURST_LEN(BL), .ADDR_STEP(8),
        .WR_ADDR_BEGIN(0), .WR_ADDR_END(511), .RD_ADDR_BEGIN(0), .RD_ADDR_END(511),
        .FIFO_DEPTH(FDEPTH), .CNT_W(CNT_W)
    ) dut (
        .ui_clk(ui_clk),
        .ui_rst_n(ui_rst_n),
        .init_calib_complete(init_calib_complete),
        .wr_addr_clr(wr_addr_clr),
        .rd_addr_clr(rd_addr_clr),
        .bus(bus)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct packed { logic [2:0] cmd; logic [ADDR_W-1:0] addr; } cmd_t;
    typedef struct { logic [APP_DW-1:0] data; int cyc; } rdexp_t;
    typedef struct {
        int wr_words; int rd_words; bit rnd; int lat; bit bst;
        int nb; bit [7:0] dirs; int wr_start; int rd_start;
    } vec_t;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [APP_DW-1:0] wmem [0:1023];
    int wr_ptr = 0, rd_ptr = 0;
    int rd_budget = 0, outstanding = 0;
    bit rand_rdy = 1'b0, bursty = 1'b0;
    int rd_lat = 3;
    int calib_en_seen = 0;
    cmd_t exp_cmd_q[$];
    logic [APP_DW-1:0] exp_wdata_q[$];
    rdexp_t exp_rd_q[$];
    int resp_q[$];
    cmd_t mon_e;
    logic [APP_DW-1:0] mon_wd, resp_d;
    rdexp_t mon_r;

    assign bus.wrfifo_dout   = wmem[rd_ptr[9:0]];
    assign bus.wrfifo_rd_cnt = CNT_W'(wr_ptr - rd_ptr);
    assign bus.rdfifo_wr_cnt = CNT_W'(FDEPTH - rd_budget);

    function automatic logic [APP_DW-1:0] rand_word();
        logic [APP_DW-1:0] w;
        for (int i = 0; i < APP_DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    always @(posedge ui_clk) begin
        cyc <= cyc + 1;
        if (!ui_rst_n) rd_ptr <= 0;
        else if (bus.wrfifo_rden) rd_ptr <= rd_ptr + 1;
    end

    // MIG model: ready strobes and in-order read returns after rd_lat cycles.
    initial begin
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data = '0;
        forever begin
            @(posedge ui_clk); #1;
            bus.app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.app_wdf_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_q.size() > 0 && cyc >= resp_q[0] + rd_lat &&
                (!bursty || $urandom_range(0, 2) != 0)) begin
                void'(resp_q.pop_front());
                resp_d = rand_word();
                bus.app_rd_data = resp_d;
                bus.app_rd_data_valid = 1'b1;
                exp_rd_q.push_back('{resp_d, cyc + 1});
                outstanding--;
            end else begin
                bus.app_rd_data_valid = 1'b0;
            end
        end
    end

    always @(negedge ui_clk) begin
        if (ui_rst_n) begin
            if (!init_calib_complete && bus.app_en) calib_en_seen++;
            if (bus.app_en && bus.app_rdy) begin
                n_vec++;
                if (exp_cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_cmd: got cmd=%0d addr=%0d, required no command", bus.app_cmd, bus.app_addr);
                end else begin
                    mon_e = exp_cmd_q.pop_front();
                    if (bus.app_cmd !== mon_e.cmd || bus.app_addr !== mon_e.addr) begin
                        n_err++;
                        $display("FAIL cmd_addr: got cmd=%0d addr=%0d, required cmd=%0d addr=%0d",
                                 bus.app_cmd, bus.app_addr, mon_e.cmd, mon_e.addr);
                    end
                end
                n_vec++;
                if (bus.app_cmd == 3'b000) begin
                    mon_wd = (exp_wdata_q.size() > 0) ? exp_wdata_q.pop_front() : '0;
                    if (!(bus.app_wdf_wren && bus.app_wdf_end && bus.wrfifo_rden) ||
                        bus.app_wdf_data !== mon_wd || outstanding != 0) begin
                        n_err++;
                        $display("FAIL wr_beat: got wren=%b end=%b rden=%b outst=%0d data=%h, required 1/1/1 outst=0 data=%h",
                                 bus.app_wdf_wren, bus.app_wdf_end, bus.wrfifo_rden, outstanding, bus.app_wdf_data, mon_wd);
                    end
                end else begin
                    if (bus.app_wdf_wren || outstanding >= BL) begin
                        n_err++;
                        $display("FAIL rd_cmd: got wren=%b outstanding=%0d, required wren=0 outstanding<%0d",
                                 bus.app_wdf_wren, outstanding, BL);
                    end
                    outstanding++;
                    rd_budget--;
                    resp_q.push_back(cyc);
                end
            end else if (bus.app_wdf_wren || bus.wrfifo_rden || bus.app_wdf_end) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_beat: got wren=%b rden=%b without accepted command, required 0",
                         bus.app_wdf_wren, bus.wrfifo_rden);
            end
            if (bus.rdfifo_wren) begin
                n_vec++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rdfifo_push: got unexpected push, required none");
                end else begin
                    mon_r = exp_rd_q.pop_front();
                    if (bus.rdfifo_din !== mon_r.data || cyc != mon_r.cyc) begin
                        n_err++;
                        $display("FAIL rdfifo_push: got cyc=%0d data=%h, required cyc=%0d data=%h",
                                 cyc, bus.rdfifo_din, mon_r.cyc, mon_r.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ui_clk); #1;
    endtask

    task automatic chk(input string name, input logic [APP_DW-1:0] act, input logic [APP_DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_words(input int n);
        logic [APP_DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            wmem[wr_ptr[9:0]] = w;
            exp_wdata_q.push_back(w);
            wr_ptr++;
        end
    endtask

    task automatic exp_burst(input bit rd, input int start);
        for (int j = 0; j < BL; j++)
            exp_cmd_q.push_back('{rd ? 3'b001 : 3'b000, ADDR_W'(start + 8*j)});
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge ui_clk);
            done = (exp_cmd_q.size() == 0 && outstanding == 0 && resp_q.size() == 0 && exp_rd_q.size() == 0);
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d commands still pending, required 0", name, exp_cmd_q.size());
            exp_cmd_q.delete(); exp_wdata_q.delete(); exp_rd_q.delete(); resp_q.delete();
            outstanding = 0; rd_budget = 0;
        end
        repeat (4) @(negedge ui_clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_app_en", 256'(bus.app_en), 256'(0));
        chk("rst_app_wdf_wren", 256'(bus.app_wdf_wren), 256'(0));
        chk("rst_app_wdf_end", 256'(bus.app_wdf_end), 256'(0));
        chk("rst_wrfifo_rden", 256'(bus.wrfifo_rden), 256'(0));
        chk("rst_rdfifo_wren", 256'(bus.rdfifo_wren), 256'(0));
        chk("rst_app_cmd", 256'(bus.app_cmd), 256'(0));
        chk("rst_app_addr", 256'(bus.app_addr), 256'(0));
        chk("rst_rdfifo_din", bus.rdfifo_din, 256'(0));
    endtask

    vec_t vt [5];

    initial begin
        int wk, rk;
        bit found;
        // {wr_words, rd_words, rand_rdy, rd_lat, bursty, bursts, dirs(1=read), wr_start, rd_start}
        vt[0] = '{16, 16, 1'b0, 3,  1'b0, 4, 8'b0000_1010, 0,   0};
        vt[1] = '{8,  0,  1'b1, 3,  1'b0, 1, 8'b0000_0000, 128, 0};
        vt[2] = '{8,  8,  1'b0, 20, 1'b1, 2, 8'b0000_0001, 192, 128};
        vt[3] = '{40, 0,  1'b1, 3,  1'b0, 5, 8'b0000_0000, 256, 0};
        vt[4] = '{0,  48, 1'b1, 3,  1'b1, 6, 8'b0011_1111, 0,   192};

        repeat (3) tick();
        check_reset_outputs();
        ui_rst_n = 1'b1;
        init_calib_complete = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            rand_rdy = vt[v].rnd;
            rd_lat   = vt[v].lat;
            bursty   = vt[v].bst;
            wk = 0; rk = 0;
            for (int b = 0; b < vt[v].nb; b++) begin
                if (vt[v].dirs[b]) begin
                    exp_burst(1'b1, (vt[v].rd_start + 64*rk) % 512); rk++;
                end else begin
                    exp_burst(1'b0, (vt[v].wr_start + 64*wk) % 512); wk++;
                end
            end
            tick();
            push_words(vt[v].wr_words);
            rd_budget += vt[v].rd_words;
            drain($sformatf("vec%0d", v), 4000);
        end
        rand_rdy = 1'b0; bursty = 1'b0; rd_lat = 3;

        // Write-address clear while idle: the next write burst restarts at 0.
        tick(); wr_addr_clr = 1'b1;
        tick(); wr_addr_clr = 1'b0;
        tick(); tick();
        exp_burst(1'b0, 0);
        push_words(8);
        drain("wr_clr", 2000);

        // Read-address clear mid-burst: burst 192..248 completes, next burst at 0.
        exp_burst(1'b1, 64); exp_burst(1'b1, 128); exp_burst(1'b1, 192);
        tick();
        rd_budget += 24;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge ui_clk);
            found = bus.app_en && bus.app_rdy && bus.app_cmd == 3'b001 && bus.app_addr == ADDR_W'(200);
        end
        chk("rd_addr_200_seen", 256'(found), 256'(1));
        tick(); rd_addr_clr = 1'b1;
        tick(); rd_addr_clr = 1'b0;
        drain("rd_clr_a", 2000);
        exp_burst(1'b1, 0);
        tick();
        rd_budget += 8;
        drain("rd_clr_b", 2000);

        // Fresh reset, calibration held low with a full write FIFO.
        tick();
        ui_rst_n = 1'b0;
        init_calib_complete = 1'b0;
        wr_ptr = 0;
        repeat (3) tick();
        check_reset_outputs();
        ui_rst_n = 1'b1;
        push_words(64);
        calib_en_seen = 0;
        repeat (100) tick();
        chk("no_app_en_uncalibrated", 256'(calib_en_seen), 256'(0));
        for (int b = 0; b < 8; b++) exp_burst(1'b0, 64*b);
        init_calib_complete = 1'b1;
        drain("calib", 3000);
        exp_burst(1'b0, 0);
        tick();
        push_words(8);
        drain("wr_wrap", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ddr3_rw_arbiter.md
# ddr3_rw_arbiter

- Sits between the 2-port DDR3 controller's write-side FIFO, its read-side FIFO and the MIG user (app) interface, all in the MIG UI clock domain.
- Schedules fixed-length write bursts, which drain the write FIFO into DDR3, and read bursts, which refill the read FIFO from DDR3.
- Shares the single app command port between the two directions with round-robin arbitration.
- Walks independent circular address windows for each direction.

## Interface
Parameters:
- APP_DW, 256, app data width; FIFO data width matches.
- ADDR_W, 28, app_addr width.
- BURST_LEN, 8, app commands per burst, power of two, ≥2.
- ADDR_STEP, 8, app_addr increment per command.
- WR_ADDR_BEGIN, 0, first write address.
- WR_ADDR_END, 511, last valid write address, inclusive.
- RD_ADDR_BEGIN, 0, first read address.
- RD_ADDR_END, 511, last valid read address, inclusive.
- FIFO_DEPTH, 64, read FIFO depth in APP_DW words.
- CNT_W, 9, width of the FIFO count inputs.

Ports:
- ui_clk  in  1  MIG UI clock.
- ui_rst_n  in  1  reset; one clock, asynchronous, active-low.
- init_calib_complete  in  1  MIG calibration done.
- wr_addr_clr  in  1  one-cycle pulse; reload the write address to WR_ADDR_BEGIN.
- rd_addr_clr  in  1  one-cycle pulse; reload the read address to RD_ADDR_BEGIN.
- wrfifo_rd_cnt  in  CNT_W  words available in the write FIFO.
- wrfifo_dout  in  APP_DW  write FIFO head word; FIFO is first-word-fall-through.
- wrfifo_rden  out  1  pop the write FIFO.
- rdfifo_wr_cnt  in  CNT_W  words held in the read FIFO.
- rdfifo_wren  out  1  push to the read FIFO.
- rdfifo_din  out  APP_DW  read FIFO write data.
- app_addr  out  ADDR_W  command address.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted.
- app_wdf_data  out  APP_DW  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  last beat; equals app_wdf_wren.
- app_wdf_rdy  in  1  write data accepted.
- app_rd_data  in  APP_DW  read data.
- app_rd_data_valid  in  1  read data valid.

## Operation
States:
- IDLE
- WR_BURST
- RD_CMD
- RD_WAIT

Request conditions, evaluated in IDLE only:
- wr_req = init_calib_complete && wrfifo_rd_cnt ≥ BURST_LEN.
- rd_req = init_calib_complete && FIFO_DEPTH − rdfifo_wr_cnt ≥ BURST_LEN.

Arbitration from IDLE:
- Only wr_req: go to WR_BURST.
- Only rd_req: go to RD_CMD.
- Both: grant the direction not granted last. The last_grant register resets to "read", so write wins the first tie.

WR_BURST:
- app_en = app_wdf_rdy.
- app_wdf_wren = app_wdf_end = wrfifo_rden = app_rdy && app_wdf_rdy.
- app_wdf_data = wrfifo_dout.
- A beat completes only when both ready inputs are high, so command and data are always accepted in the same cycle.
- After BURST_LEN beats, go to IDLE.

RD_CMD:
- app_en = 1; each cycle with app_rdy high is one accepted command.
- After BURST_LEN accepted commands, go to RD_WAIT.

RD_WAIT:
- Stay until BURST_LEN app_rd_data_valid beats have been counted since the burst began. Valids that arrive during RD_CMD also count.
- Then go to IDLE.

Read data path, active in every state:
- rdfifo_wren and rdfifo_din are app_rd_data_valid and app_rd_data registered once.

Addresses:
- app_addr = wr_addr in WR_BURST, rd_addr in RD_CMD, wr_addr otherwise.
- After each accepted command, the address becomes BEGIN if addr + ADDR_STEP > END; otherwise addr + ADDR_STEP.
- The addition is ADDR_W+1 bits wide, so the comparison cannot overflow.

Address clears:
- A wr_addr_clr or rd_addr_clr pulse sets a sticky pending flag.
- The flag is applied and cleared at the next cycle in IDLE, including a clear that arrives while already in IDLE.
- No grant is made in that cycle.
- A burst in progress always completes on its original address sequence.

Calibration:
- init_calib_complete is sampled only in IDLE; a drop mid-burst does not abort the burst.

## Timing
Reset values:
- State IDLE, last_grant = read.
- wr_addr = WR_ADDR_BEGIN, rd_addr = RD_ADDR_BEGIN.
- app_en, app_wdf_wren, app_wdf_end, wrfifo_rden, rdfifo_wren all 0.
- app_cmd = 3'b000, app_addr = WR_ADDR_BEGIN, rdfifo_din = 0.
- All counters 0, both clear-pending flags 0.

Cycle-level behaviour:
- IDLE→burst takes 1 cycle, so there is at least one IDLE cycle between bursts.
- A write burst with both ready inputs held high takes exactly BURST_LEN cycles.
- Read data reaches the read FIFO 1 cycle after app_rd_data_valid.
- Only app_en, app_wdf_wren, app_wdf_end and wrfifo_rden may depend combinationally on app_rdy and app_wdf_rdy; all other outputs are registered.
- Never more than BURST_LEN reads outstanding; the read FIFO cannot overflow provided rdfifo_wr_cnt never under-reports.

## Test plan
- After reset, hold init_calib_complete = 0 with wrfifo_rd_cnt = 64 → no app_en for 100 cycles. Raise it → write burst at app_addr 0, 8, …, 56; 8 wrfifo_rden pulses; next write burst starts at 64.
- Both requests pending on the first IDLE cycle → write granted first. Grants then alternate W, R, W, R over 4 bursts.
- Toggle app_rdy and app_wdf_rdy randomly during a write burst → exactly 8 beats; app_en, app_wdf_wren and wrfifo_rden coincide on accepted beats; FIFO words appear in order.
- Write 64 commands with END = 511, STEP = 8 → the 65th command uses app_addr 0. The same wrap applies to the read window.
- Read burst with app_rd_data_valid delayed by 20 cycles and bursty → 8 rdfifo_wren pulses, each 1 cycle after its valid; no new grant before the 8th.
- Pulse rd_addr_clr mid read burst at rd_addr = 200 → the burst finishes at 248; the next read burst starts at RD_ADDR_BEGIN.
